// File: rtl/char_stream_loader.sv
// rtl/char_stream_loader.sv - message buffer that feeds a display register one character per DIV cycles
module char_stream_loader #(
  parameter int N     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DIV   = 50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW:0]   msg_len,
  input  logic          start,
  input  logic          stop,
  output logic [N-1:0]  data_out,
  output logic          load,
  output logic          busy,
  output logic [AW-1:0] idx
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [N-1:0]  mem [DEPTH];
  logic [1:0]    state;
  logic [PW-1:0] pre;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] last_idx;
  logic          start_q;
  logic          len_ok;

  assign len_ok = (msg_len != '0) && (msg_len <= (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // start passes through one register, so the first strobe lands two edges after the request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pre      <= '0;
      rd_ptr   <= '0;
      last_idx <= '0;
      start_q  <= 1'b0;
      data_out <= '0;
      load     <= 1'b0;
      busy     <= 1'b0;
      idx      <= '0;
    end else begin
      start_q <= start && !stop && (state == IDLE);
      load    <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
        pre   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_q && len_ok) begin
              last_idx <= AW'(msg_len - 1'b1);
              rd_ptr   <= '0;
              state    <= EMIT;
              busy     <= 1'b1;
            end
          end
          EMIT: begin
            data_out <= mem[rd_ptr];
            load     <= 1'b1;
            idx      <= rd_ptr;
            pre      <= '0;
            rd_ptr   <= (rd_ptr == last_idx) ? '0 : rd_ptr + 1'b1;
            state    <= RUN;
          end
          RUN: begin
            if (pre == PRE_LAST) begin
              pre   <= '0;
              state <= EMIT;
            end else begin
              pre <= pre + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/char_stream_loader.md
Name: char_stream_loader

Overview:
- Upstream feeder for the rotating display register in the uname-display project.
- Holds a short character message in a small register file, written by the host side.
- While running, presents one character at a time on data_out with a single-cycle load strobe, paced by an internal prescaler.
- Wraps around at the programmed message length, so the downstream register is reloaded with successive characters.

Parameters:
- N, 8, character/data width; matches the downstream register width.
- DEPTH, 16, message buffer entries.
- AW, 4, buffer address width; DEPTH = 2**AW.
- DIV, 50000, clock cycles between successive load strobes; legal range 2 or more.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; the block is held in reset while reset=0.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  AW  buffer write address.
- wr_data  input  N  buffer write data.
- msg_len  input  AW+1  number of valid characters, 1..DEPTH; sampled only when start is accepted.
- start  input  1  begin streaming from entry 0.
- stop  input  1  halt streaming.
- data_out  output  N  current character; drives the downstream data_in.
- load  output  1  one-cycle strobe; drives the downstream load.
- busy  output  1  high while not in IDLE.
- idx  output  AW  index of the character last presented on data_out.

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, load=0, busy=0, idx=0, state=IDLE, prescaler=0, latched length=0.
  - All buffer entries cleared to 0.
- Buffer writes:
  - wr_en=1 writes wr_data to buf[wr_addr] at the clock edge, in any state.
  - Read-before-write: if a write and a load of the same entry fall on the same edge, the old value is presented. The new value appears on the next pass.
- All outputs are registered.
- FSM states are IDLE, EMIT, RUN.
- IDLE:
  - start=1, stop=0 and 1<=msg_len<=DEPTH: latch msg_len, set rd_ptr=0, go to EMIT.
  - start with msg_len=0 or msg_len>DEPTH: ignored, stay in IDLE.
- EMIT (lasts one cycle):
  - On leaving: data_out<=buf[rd_ptr], load<=1, idx<=rd_ptr, prescaler<=0.
  - rd_ptr advances, wrapping from latched length-1 to 0.
  - Next state is RUN.
- RUN:
  - load is 0 on every cycle except the one after EMIT.
  - Prescaler increments each cycle. When it reaches DIV-2, go to EMIT.
  - Result: load pulses are spaced exactly DIV cycles apart.
- Timing:
  - start sampled at edge k puts EMIT in the cycle after edge k+1.
  - load is high, with data_out=buf[0], for the single cycle after edge k+2.
- stop=1:
  - In any state, the next state is IDLE and load is forced to 0 at that edge.
  - data_out and idx hold their last values; the prescaler clears.
- start and stop asserted together: stop wins.
- start while busy: ignored; a restart requires stop, then start.
- Changing msg_len while busy has no effect until the next accepted start.
- msg_len=1: the same entry is reloaded every DIV cycles and idx stays 0.
- Prescaler width is clog2(DIV). Overflow is never reached because the count is bounded by DIV-2.
- Reset is sampled asynchronously mid-stream. It aborts immediately to the reset values and no load pulse is produced on reset release.
- busy = (state != IDLE).

Test Plan (DIV=4, N=8, DEPTH=16):
- Reset, then check outputs -> data_out=0x00, load=0, busy=0, idx=0. Write "LINU" (0x4C,0x49,0x4E,0x55) to addresses 0..3 and read back via streaming.
- msg_len=4, pulse start -> load high 2 cycles later with data_out=0x4C. Subsequent loads every 4 cycles with 0x49, 0x4E, 0x55, then 0x4C again (wrap); idx follows 0,1,2,3,0.
- msg_len=0 or msg_len=17 with start -> busy stays 0 and no load ever asserts.
- While running, assert stop on a cycle the prescaler would trigger EMIT -> load stays 0, busy=0, data_out holds its last character. Assert start and stop together -> stays IDLE.
- Write 0x41 to address 1 on the same edge as the load of entry 1 -> 0x49 is presented; the next pass presents 0x41.
- Drive reset=0 asynchronously mid-RUN, between clock edges -> outputs clear immediately. After release, no load occurs until a new start.
